simon_sequencer: RTL and testbench
==================================

Name: simon_sequencer

Overview:
- Game controller for the Simon Says number memory (16 x 2-bit, registered read, rw 0=read / 1=write).
- Each round it appends one pseudo-random number to the sequence, plays the whole sequence out to the display, then checks player button presses against memory.
- It is the only master of the memory's address, rw and in_num pins. The top level instantiates it beside mem.

Parameters:
- MAX_LEN, 11: sequence length that wins the game; legal range 1..16.
- SHOW_CYCLES, 25_000_000: cycles each number is displayed.
- GAP_CYCLES, 12_500_000: dark cycles between displayed numbers.
- TIMEOUT_CYCLES, 250_000_000: maximum wait for each button press before a loss.
- LFSR_SEED, 8'hA5: reset value of the LFSR; must be nonzero.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a new game in IDLE, WIN or LOSE.
- btn_valid  in  1  single-cycle pulse; a player press is present.
- btn_num  in  2  number pressed (0..3); qualified by btn_valid.
- mem_out_num  in  2  mem read data; valid one cycle after the address is presented with rw=0.
- mem_address  out  4  to mem address.
- mem_rw  out  1  to mem rw.
- mem_in_num  out  2  to mem in_num.
- show_valid  out  1  display lamp on.
- show_num  out  2  number being displayed.
- level  out  4  current sequence length.
- busy  out  1  game in progress (any state except IDLE/WIN/LOSE).
- win  out  1  held high in WIN.
- lose  out  1  held high in LOSE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; len=0; idx=0; all timers 0; lfsr=LFSR_SEED.
  - All outputs reset to 0.
  - mem contents are not cleared; they are irrelevant because every game rewrites them before reading.
- mem_rw is 1 only in GEN. In every other state mem_rw=0 and mem_address=idx.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Free-running: advances every cycle out of reset, so the sequence depends on player timing.
- States and transitions:
  - IDLE: start -> GEN with len=0.
  - GEN (1 cycle): mem_address=len, mem_rw=1, mem_in_num=lfsr[1:0]. Then len<=len+1, idx<=0 -> SHOW_RD.
  - SHOW_RD (1 cycle): address idx is presented -> SHOW_LAT.
  - SHOW_LAT (1 cycle): show_num<=mem_out_num -> SHOW_ON.
  - SHOW_ON: show_valid=1 for exactly SHOW_CYCLES cycles -> SHOW_GAP.
  - SHOW_GAP: show_valid=0 for GAP_CYCLES cycles.
    - At exit: if idx==len-1, then idx<=0 -> IN_RD.
    - Else idx<=idx+1 -> SHOW_RD.
  - IN_RD (1 cycle): address presented; timeout counter cleared -> IN_WAIT.
  - IN_WAIT: mem_out_num holds expected[idx].
    - btn_valid with btn_num!=mem_out_num -> LOSE.
    - btn_valid with a match and idx<len-1: idx<=idx+1 -> IN_RD.
    - btn_valid with a match and idx==len-1: if len==MAX_LEN -> WIN, else GEN.
    - No press for TIMEOUT_CYCLES cycles -> LOSE.
  - WIN / LOSE: respective flag high; level holds the final len. start -> GEN with len=0 and flags cleared.
- Ignored inputs:
  - btn_valid outside IN_WAIT is ignored.
  - start while busy=1 is ignored.
  - start and btn_valid in the same cycle in IN_WAIT: btn_valid is evaluated; start is ignored.
- Latencies:
  - start to first write: 1 cycle.
  - Write to first show_valid: 3 cycles.
  - btn_valid to WIN/LOSE flag: 1 cycle.
- level = len, registered. It is 1 during the first round and never exceeds MAX_LEN.
- Counters are sized by $clog2 of their parameter. Each counter compares against parameter-1 and restarts from 0 on every state entry.

Decomposition:
- simon_pkg holds:
  - typedef num_t (logic [1:0]); typedef addr_t (logic [3:0]);
  - state enum state_t (IDLE, GEN, SHOW_RD, SHOW_LAT, SHOW_ON, SHOW_GAP, IN_RD, IN_WAIT, WIN, LOSE);
  - constant LFSR_TAPS=8'hB8.
- One sub-module, simon_lfsr: 8-bit, with clock, reset_n and a seed parameter; output state[7:0].
- FSM, idx/len registers and the shared cycle timer live in simon_sequencer.

Test Plan:
- Reset mid-SHOW_ON (reset_n low for 1 cycle) -> IDLE immediately; show_valid=0, level=0, busy=0; start then writes address 0 again.
- Bench parameters SHOW_CYCLES=4, GAP_CYCLES=2, MAX_LEN=3. Start -> one GEN write at address 0, then one show_valid pulse 4 cycles wide with show_num equal to the written value.
- Player correct through 3 rounds with a behavioural mem model -> writes at addresses 0, 1, 2; show pulse counts 1, 2, 3; win=1 with level=3 one cycle after the last press.
- Round 2, second press wrong -> lose=1 the next cycle, level=2; later presses ignored; start -> GEN write at address 0 and level=1.
- TIMEOUT_CYCLES=8 with no press -> lose asserts exactly 8 cycles after entering IN_WAIT.
- btn_valid pulses during SHOW_ON/SHOW_GAP and start pulses during play -> no state change; sequence and display timing unchanged.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequencer.
package simon_pkg;

  typedef logic [1:0] num_t;
  typedef logic [3:0] addr_t;

  typedef enum logic [3:0] {
    IDLE,
    GEN,
    SHOW_RD,
    SHOW_LAT,
    SHOW_ON,
    SHOW_GAP,
    IN_RD,
    IN_WAIT,
    WIN,
    LOSE
  } state_t;

  // Feedback mask for taps 8,6,5,4 (bit 8 is the MSB).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; supplies the random numbers for each round.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [7:0] state
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game controller: grows the sequence, plays it to the display and
// checks the player's presses against the memory that holds it.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int         MAX_LEN        = 11,
  parameter int         SHOW_CYCLES    = 25_000_000,
  parameter int         GAP_CYCLES     = 12_500_000,
  parameter int         TIMEOUT_CYCLES = 250_000_000,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn_num,
  input  logic [1:0] mem_out_num,
  output logic [3:0] mem_address,
  output logic       mem_rw,
  output logic [1:0] mem_in_num,
  output logic       show_valid,
  output logic [1:0] show_num,
  output logic [3:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose,
  output logic [3:0] dbg_state_o
);

  localparam int TW_SHOW = cnt_width(SHOW_CYCLES);
  localparam int TW_GAP  = cnt_width(GAP_CYCLES);
  localparam int TW_TO   = cnt_width(TIMEOUT_CYCLES);
  localparam int TW_SG   = (TW_SHOW > TW_GAP) ? TW_SHOW : TW_GAP;
  localparam int TW      = (TW_SG > TW_TO) ? TW_SG : TW_TO;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  // Handshake: start and btn_valid are single-cycle pulses sampled on the
  // rising edge; each is acted on only in the states that accept it and is
  // otherwise dropped, with btn_valid taking priority in IN_WAIT.

  state_t        state_q, state_d;
  logic [4:0]    len_q, len_d;
  addr_t         idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  num_t          show_num_q, show_num_d;

  logic [7:0]    lfsr_state;
  logic          lfsr_unused;
  logic          last_idx;

  simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .state   (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state[7:2];
  assign last_idx    = ({1'b0, idx_q} == (len_q - 5'd1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    timer_d    = '0;
    show_num_d = show_num_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_d = GEN;
          len_d   = '0;
        end
      end
      GEN: begin
        len_d   = len_q + 5'd1;
        idx_d   = '0;
        state_d = SHOW_RD;
      end
      SHOW_RD: state_d = SHOW_LAT;
      SHOW_LAT: begin
        show_num_d = mem_out_num;
        state_d    = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer_q == SHOW_LAST) state_d = SHOW_GAP;
        else                      timer_d = timer_q + TW'(1);
      end
      SHOW_GAP: begin
        if (timer_q == GAP_LAST) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = IN_RD;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SHOW_RD;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      IN_RD: state_d = IN_WAIT;
      IN_WAIT: begin
        // mem_out_num already holds the expected number for idx here.
        if (btn_valid) begin
          if (btn_num != mem_out_num) begin
            state_d = LOSE;
          end else if (!last_idx) begin
            idx_d   = idx_q + 4'd1;
            state_d = IN_RD;
          end else if (len_q == 5'(MAX_LEN)) begin
            state_d = WIN;
          end else begin
            state_d = GEN;
          end
        end else if (timer_q == TO_LAST) begin
          state_d = LOSE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      show_num_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      show_num_q <= show_num_d;
    end
  end

  always_comb begin
    mem_rw      = (state_q == GEN);
    mem_address = (state_q == GEN) ? len_q[3:0] : idx_q;
    mem_in_num  = (state_q == GEN) ? lfsr_state[1:0] : 2'd0;
    show_valid  = (state_q == SHOW_ON);
    show_num    = show_num_q;
    level       = len_q[3:0];
    busy        = !((state_q == IDLE) || (state_q == WIN) || (state_q == LOSE));
    win         = (state_q == WIN);
    lose        = (state_q == LOSE);
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: per-cycle expected outputs come from a round
// timeline model plus an LFSR model; a memory model sits beside the DUT.
module tb_simon_sequencer;

  localparam int MAX_LEN = 3;
  localparam int SHOW    = 4;
  localparam int GAP     = 2;
  localparam int TMO     = 8;

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       start     = 1'b0;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_num   = 2'd0;
  logic [1:0] mem_out_num;
  logic [3:0] mem_address;
  logic       mem_rw;
  logic [1:0] mem_in_num;
  logic       show_valid;
  logic [1:0] show_num;
  logic [3:0] level;
  logic       busy;
  logic       win;
  logic       lose;
  logic [3:0] dbg_state;

  always #5 clock = ~clock;

  simon_sequencer #(
    .MAX_LEN        (MAX_LEN),
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .btn_valid   (btn_valid),
    .btn_num     (btn_num),
    .mem_out_num (mem_out_num),
    .mem_address (mem_address),
    .mem_rw      (mem_rw),
    .mem_in_num  (mem_in_num),
    .show_valid  (show_valid),
    .show_num    (show_num),
    .level       (level),
    .busy        (busy),
    .win         (win),
    .lose        (lose),
    .dbg_state_o (dbg_state)
  );

  // 16 x 2-bit memory with registered read.
  logic [1:0] mem [16];
  always @(posedge clock) begin
    if (mem_rw) mem[mem_address] <= mem_in_num;
    mem_out_num <= mem[mem_address];
  end

  // Reference LFSR, taps 8,6,5,4 counted from 1 at the LSB.
  logic [7:0] m_lfsr;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 8'hA5;
    else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct packed {
    logic       rw;
    logic [3:0] addr;
    logic       sv;
    logic [3:0] sidx;
    logic [3:0] lvl;
    logic       busy;
    logic       win;
    logic       lose;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [1:0] seq [16];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         pulses = 0;
  logic       sv_prev = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (show_valid && !sv_prev) pulses <= pulses + 1;
    sv_prev <= show_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t ex(input int rw, input int addr, input int sv, input int sidx,
                              input int lvl, input int bsy, input int w, input int l);
    exp_t e;
    e.rw   = 1'(rw);
    e.addr = 4'(addr);
    e.sv   = 1'(sv);
    e.sidx = 4'(sidx);
    e.lvl  = 4'(lvl);
    e.busy = 1'(bsy);
    e.win  = 1'(w);
    e.lose = 1'(l);
    return e;
  endfunction

  // Scoreboard: one expected output vector per cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk($sformatf("mem_rw@%0d", cyc), 32'(mem_rw), 32'(cur.rw));
      chk($sformatf("mem_address@%0d", cyc), 32'(mem_address), 32'(cur.addr));
      if (cur.rw) begin
        chk($sformatf("mem_in_num@%0d", cyc), 32'(mem_in_num), 32'(m_lfsr[1:0]));
        seq[cur.addr] = m_lfsr[1:0];
      end
      chk($sformatf("show_valid@%0d", cyc), 32'(show_valid), 32'(cur.sv));
      if (cur.sv) chk($sformatf("show_num@%0d", cyc), 32'(show_num), 32'(seq[cur.sidx]));
      chk($sformatf("level@%0d", cyc), 32'(level), 32'(cur.lvl));
      chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(cur.busy));
      chk($sformatf("win@%0d", cyc), 32'(win), 32'(cur.win));
      chk($sformatf("lose@%0d", cyc), 32'(lose), 32'(cur.lose));
    end
  end

  // One cycle: expected outputs for this cycle, inputs for the next edge.
  task automatic tick(input exp_t e, input logic st, input logic bv, input logic [1:0] bn);
    @(posedge clock);
    #1;
    exp_q.push_back(e);
    start     = st;
    btn_valid = bv;
    btn_num   = bn;
  endtask

  // Round of length L from its GEN cycle through IN_RD; noise adds ignored pulses.
  task automatic round(input int L, input logic noise);
    tick(ex(1, L - 1, 0, 0, L - 1, 1, 0, 0), 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < L; i++) begin
      repeat (2) tick(ex(0, i, 0, 0, L, 1, 0, 0), 1'b0, 1'b0, 2'd0);
      for (int k = 0; k < SHOW; k++)
        tick(ex(0, i, 1, i, L, 1, 0, 0), 1'b0, noise, 2'($urandom_range(3, 0)));
      for (int k = 0; k < GAP; k++)
        tick(ex(0, i, 0, 0, L, 1, 0, 0), noise, 1'b0, 2'd0);
    end
    tick(ex(0, 0, 0, 0, L, 1, 0, 0), 1'b0, 1'b0, 2'd0);
  endtask

  // Player presses for a round of length L; wrong_at < 0 means all correct.
  task automatic answer(input int L, input int wrong_at, input int dly);
    logic [1:0] v;
    for (int i = 0; i < L; i++) begin
      for (int w = 0; w < dly; w++)
        tick(ex(0, i, 0, 0, L, 1, 0, 0), (w == 0), 1'b0, 2'd0);
      v = seq[4'(i)];
      if (i == wrong_at) v = v + 2'd1;
      tick(ex(0, i, 0, 0, L, 1, 0, 0), (dly == 1), 1'b1, v);
      if (i == wrong_at) return;
      if (i < L - 1) tick(ex(0, i + 1, 0, 0, L, 1, 0, 0), 1'b0, 1'b0, 2'd0);
    end
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_in_num", 32'(mem_in_num), 32'd0);
    chk("rst_show_valid", 32'(show_valid), 32'd0);
    chk("rst_show_num", 32'(show_num), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_win", 32'(win), 32'd0);
    chk("rst_lose", 32'(lose), 32'd0);
    chk("model_lfsr_seed", 32'(m_lfsr), 32'h A5);
    reset_n = 1'b1;

    // Game A: three correct rounds to a win.
    tick(ex(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 2'd0);
    p0 = pulses;
    round(1, 1'b0);
    chk("model_first_write", 32'(seq[0]), 32'd1);
    chk("mem_first_write", 32'(mem[0]), 32'd1);
    answer(1, -1, 2);
    round(2, 1'b1);
    answer(2, -1, 1);
    round(3, 1'b0);
    answer(3, -1, 0);
    tick(ex(0, 2, 0, 0, 3, 0, 1, 0), 1'b0, 1'b1, 2'd0);
    @(negedge clock);
    chk("win_flag", 32'(win), 32'd1);
    chk("win_level", 32'(level), 32'd3);
    chk("show_pulses_game_a", 32'(pulses - p0), 32'd6);
    tick(ex(0, 2, 0, 0, 3, 0, 1, 0), 1'b1, 1'b0, 2'd0);

    // Game B: wrong second press in round 2, then a timeout.
    round(1, 1'b0);
    answer(1, -1, 0);
    round(2, 1'b0);
    answer(2, 1, 0);
    tick(ex(0, 1, 0, 0, 2, 0, 0, 1), 1'b0, 1'b1, seq[1]);
    @(negedge clock);
    chk("lose_flag", 32'(lose), 32'd1);
    chk("lose_level", 32'(level), 32'd2);
    tick(ex(0, 1, 0, 0, 2, 0, 0, 1), 1'b0, 1'b1, seq[0]);
    tick(ex(0, 1, 0, 0, 2, 0, 0, 1), 1'b1, 1'b0, 2'd0);
    round(1, 1'b0);
    repeat (TMO) tick(ex(0, 0, 0, 0, 1, 1, 0, 0), 1'b0, 1'b0, 2'd0);
    tick(ex(0, 0, 0, 0, 1, 0, 0, 1), 1'b0, 1'b0, 2'd0);
    @(negedge clock);
    chk("timeout_lose", 32'(lose), 32'd1);
    tick(ex(0, 0, 0, 0, 1, 0, 0, 1), 1'b1, 1'b0, 2'd0);

    // Reset in the middle of SHOW_ON.
    tick(ex(1, 0, 0, 0, 0, 1, 0, 0), 1'b0, 1'b0, 2'd0);
    repeat (2) tick(ex(0, 0, 0, 0, 1, 1, 0, 0), 1'b0, 1'b0, 2'd0);
    repeat (2) tick(ex(0, 0, 1, 0, 1, 1, 0, 0), 1'b0, 1'b0, 2'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_show_valid", 32'(show_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_address", 32'(mem_address), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick(ex(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 2'd0);
    tick(ex(1, 0, 0, 0, 0, 1, 0, 0), 1'b0, 1'b0, 2'd0);
    tick(ex(0, 0, 0, 0, 1, 1, 0, 0), 1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: run still active at %0t, want finished", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
